// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller of the async FIFO (read clock domain).
// Keeps the binary read counter, RAM read address and Gray read pointer,
// and registers look-ahead EMPTY / ALMOST_EMPTY flags plus an occupancy
// count derived from the synchronised Gray write pointer.
//
// Ports:
//   R_CLK        read clock, rising edge
//   R_RST        asynchronous reset, active-high
//   R_INC        read request; pops one word per cycle while EMPTY=0
//   rq2_wptr     Gray write pointer from the double-flop synchroniser
//   R_ptr        registered Gray read pointer to the write domain
//   R_addr       RAM read address
//   EMPTY        registered empty flag
//   ALMOST_EMPTY registered, occupancy <= AE_THRESH
//   R_LEVEL      registered occupancy seen from the read side, 0..DEPTH
//   R_UNDERFLOW  registered pulse per read request while EMPTY=1
//
// Build option: define FIFO_RD_UNDERFLOW_EN to enable R_UNDERFLOW;
// otherwise it is tied to 0.

module fifo_rd_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int AE_THRESH  = 1
) (
    input  logic                  R_CLK,
    input  logic                  R_RST,
    input  logic                  R_INC,
    input  logic [ADDR_WIDTH:0]   rq2_wptr,
    output logic [ADDR_WIDTH:0]   R_ptr,
    output logic [ADDR_WIDTH-1:0] R_addr,
    output logic                  EMPTY,
    output logic                  ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]   R_LEVEL,
    output logic                  R_UNDERFLOW
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_LIM = PW'(AE_THRESH);

    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_bin_next;
    logic [PW-1:0] rd_gray_next;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;
    logic          pop;

    always_comb begin
        pop          = R_INC & ~EMPTY;
        rd_bin_next  = rd_bin + {{(PW-1){1'b0}}, pop};
        rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);
        // Gray to binary: bit i is the XOR of all Gray bits at or above i.
        wbin = '0;
        for (int i = 0; i < PW; i++) begin
            wbin[i] = ^(rq2_wptr >> i);
        end
        // Pop and write advance fold into one difference, so a
        // simultaneous pair leaves the level unchanged.
        level_next = wbin - rd_bin_next;
    end

    always_ff @(posedge R_CLK or posedge R_RST) begin
        if (R_RST) begin
            rd_bin       <= '0;
            R_ptr        <= '0;
            EMPTY        <= 1'b1;
            ALMOST_EMPTY <= 1'b1;
            R_LEVEL      <= '0;
        end else begin
            rd_bin       <= rd_bin_next;
            R_ptr        <= rd_gray_next;
            // Look-ahead: compare against the post-pop pointer so the
            // flag rises on the edge that consumes the last word.
            EMPTY        <= (rd_gray_next == rq2_wptr);
            ALMOST_EMPTY <= (level_next <= AE_LIM);
            R_LEVEL      <= level_next;
        end
    end

    assign R_addr = rd_bin[ADDR_WIDTH-1:0];

`ifdef FIFO_RD_UNDERFLOW_EN
    always_ff @(posedge R_CLK or posedge R_RST) begin
        if (R_RST) begin
            R_UNDERFLOW <= 1'b0;
        end else begin
            R_UNDERFLOW <= R_INC & EMPTY;
        end
    end
`else
    assign R_UNDERFLOW = 1'b0;
`endif

endmodule
